// File: rtl/seven_segment_mux.sv
// ---------------------------------------------------------------------------
// seven_segment_mux
//
// Two-digit multiplexed seven-segment driver for a common-cathode display.
// Latches a tens/units reading on `load`, decodes each digit to segment
// patterns, and alternates one shared segment bus between the two digits.
// Each digit is shown for REFRESH_DIV clock cycles.
//
// Parameters
//   REFRESH_DIV        clock cycles per digit slot (2..65535)
//   BLANK_LEADING_ZERO 1 = a tens value of 0 is shown blank
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset; clears all state
//   load       in   latches ten_count/unit_count on a clock edge
//   ten_count  in   [3:0] tens value (10..15 shown as overflow)
//   unit_count in   [3:0] units value (10..15 shown as a dash)
//   segments   out  [6:0] active-high segment drive, bit0 = a .. bit6 = g
//   digit      out  1 = tens digit enabled, 0 = units digit enabled
// ---------------------------------------------------------------------------
module seven_segment_mux #(
    parameter int unsigned REFRESH_DIV        = 100,
    parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic [6:0] segments,
    output logic       digit
);

    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_DASH   = 7'h40;
    localparam logic [6:0]  SEG_BLANK  = 7'h00;

    logic [3:0]  tens_q,  tens_d;
    logic [3:0]  units_q, units_d;
    logic [15:0] presc_q, presc_d;
    logic        digit_q, digit_d;
    logic [6:0]  seg_q,   seg_d;
    logic        wrap;
    logic [6:0]  tens_seg;
    logic [6:0]  units_seg;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        tens_d  = load ? ten_count  : tens_q;
        units_d = load ? unit_count : units_q;

        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? 16'd0 : presc_q + 16'd1;
        digit_d = wrap ? ~digit_q : digit_q;

        // An out-of-range tens value means the reading overflowed two digits,
        // so both slots show a dash regardless of the units value.
        if (tens_q > 4'd9) begin
            tens_seg  = SEG_DASH;
            units_seg = SEG_DASH;
        end else begin
            tens_seg  = (BLANK_LEADING_ZERO && tens_q == 4'd0) ? SEG_BLANK
                                                                : bcd_to_seg(tens_q);
            units_seg = bcd_to_seg(units_q);
        end

        // Select on the upcoming digit so segments and digit switch together.
        seg_d = digit_d ? tens_seg : units_seg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            presc_q <= 16'd0;
            digit_q <= 1'b0;
            seg_q   <= 7'h00;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign segments = seg_q;
    assign digit    = digit_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ten_count = 4'd0;
    logic [3:0] unit_count = 4'd0;
    logic [6:0] seg1, seg0;
    logic       dig1, dig0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         n;          // edges since reset release
    logic [3:0] mt, mu;     // model latches
    logic       md;         // model digit after the last edge
    logic [6:0] dec [16];

    typedef struct {
        logic [3:0] t;
        logic [3:0] u;
        logic [6:0] tens_b1;
        logic [6:0] tens_b0;
        logic [6:0] units;
        int         hold;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    seven_segment_mux #(.REFRESH_DIV(R), .BLANK_LEADING_ZERO(1'b1)) dut_b1 (
        .clk(clk), .reset(reset), .load(load),
        .ten_count(ten_count), .unit_count(unit_count),
        .segments(seg1), .digit(dig1));

    seven_segment_mux #(.REFRESH_DIV(R), .BLANK_LEADING_ZERO(1'b0)) dut_b0 (
        .clk(clk), .reset(reset), .load(load),
        .ten_count(ten_count), .unit_count(unit_count),
        .segments(seg0), .digit(dig0));

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%02h expected=%02h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic blank, input logic [3:0] t,
                                           input logic [3:0] u, input logic d);
        if (t > 4'd9) return 7'h40;
        if (d) return (blank && t == 4'd0) ? 7'h00 : dec[t];
        return dec[u];
    endfunction

    // One clock edge: advance the model, then compare both DUTs.
    task automatic tick();
        logic [6:0] e1, e0;
        logic d;
        @(posedge clk);
        n++;
        d  = ((n / R) % 2) == 1;
        e1 = exp_seg(1'b1, mt, mu, d);
        e0 = exp_seg(1'b0, mt, mu, d);
        if (load) begin
            mt = ten_count;
            mu = unit_count;
        end
        md = d;
        #1;
        chk("seg_blank1", seg1, e1);
        chk("seg_blank0", seg0, e0);
        chk("digit_blank1", {6'd0, dig1}, {6'd0, d});
        chk("digit_blank0", {6'd0, dig0}, {6'd0, d});
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_seg", seg1, 7'h00);
        chk("async_rst_digit", {6'd0, dig1}, 7'h00);
        @(posedge clk);
        #1;
        chk("rst_hold_seg", seg0, 7'h00);
        reset = 1'b0;
        n  = 0;
        mt = 4'd0;
        mu = 4'd0;
        md = 1'b0;
    endtask

    initial begin
        dec[0] = 7'h3F; dec[1] = 7'h06; dec[2] = 7'h5B; dec[3] = 7'h4F;
        dec[4] = 7'h66; dec[5] = 7'h6D; dec[6] = 7'h7D; dec[7] = 7'h07;
        dec[8] = 7'h7F; dec[9] = 7'h6F;
        for (int i = 10; i < 16; i++) dec[i] = 7'h40;

        vecs[0] = '{t: 4'd4,  u: 4'd2, tens_b1: 7'h66, tens_b0: 7'h66, units: 7'h5B, hold: 2*R};
        vecs[1] = '{t: 4'd0,  u: 4'd7, tens_b1: 7'h00, tens_b0: 7'h3F, units: 7'h07, hold: 2*R};
        vecs[2] = '{t: 4'd12, u: 4'd7, tens_b1: 7'h40, tens_b0: 7'h40, units: 7'h40, hold: 2*R};
        vecs[3] = '{t: 4'd9,  u: 4'd9, tens_b1: 7'h6F, tens_b0: 7'h6F, units: 7'h6F, hold: 2*R};
        vecs[4] = '{t: 4'd3,  u: 4'd8, tens_b1: 7'h4F, tens_b0: 7'h4F, units: 7'h7F, hold: 1000};

        // Power-on reset
        #1;
        chk("por_seg", seg1, 7'h00);
        chk("por_digit", {6'd0, dig1}, 7'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0; mt = 4'd0; mu = 4'd0; md = 1'b0;
        tick();
        chk("first_edge_3F", seg1, 7'h3F);
        for (int i = 0; i < 12; i++) tick();

        // Table-driven loads
        foreach (vecs[k]) begin
            ten_count  = vecs[k].t;
            unit_count = vecs[k].u;
            load = 1'b1;
            tick();
            load = 1'b0;
            ten_count  = 4'($urandom_range(0, 15));
            unit_count = 4'($urandom_range(0, 15));
            for (int i = 0; i < 2*R; i++) tick();
            for (int i = 0; i < vecs[k].hold; i++) begin
                tick();
                chk($sformatf("vec%0d_blank1", k), seg1, md ? vecs[k].tens_b1 : vecs[k].units);
                chk($sformatf("vec%0d_blank0", k), seg0, md ? vecs[k].tens_b0 : vecs[k].units);
            end
        end

        // Load held high while inputs change every cycle
        load = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ten_count  = 4'($urandom_range(0, 9));
            unit_count = 4'($urandom_range(0, 9));
            tick();
        end
        load = 1'b0;
        tick();

        // Load exactly on a prescaler-wrap edge
        for (int i = 0; i < 2*R && (n % R) != R - 1; i++) tick();
        ten_count  = 4'd5;
        unit_count = 4'd1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("wrap_load_new", seg1, md ? 7'h6D : 7'h06);

        // Reset mid-slot loses the reading
        tick();
        do_reset();
        tick();
        chk("post_rst_3F", seg1, 7'h3F);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 3) == 0);
            ten_count  = 4'($urandom_range(0, 15));
            unit_count = 4'($urandom_range(0, 15));
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 2*R; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
